// File: rtl/ipsxe_floating_point_lzc_norm_pipe_v1_0_pkg.sv
// Shared definitions for the pipelined leading-zero/one count and normalise block.
//   lzc_clog2      : ceil(log2(v)), v >= 1
//   lzc_next_pow2  : smallest power of two >= w (at least 2); internal search width
//   lzc_mode_e     : counted-bit polarity selected by i_mode
package ipsxe_floating_point_lzc_norm_pipe_v1_0_pkg;

  typedef enum logic {
    LZC_MODE_ZEROS = 1'b0,
    LZC_MODE_ONES  = 1'b1
  } lzc_mode_e;

  function automatic int unsigned lzc_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned lzc_next_pow2(input int unsigned w);
    if (w <= 2) return 2;
    return 32'd1 << lzc_clog2(w);
  endfunction

  // Search width for the default 49-bit operand.
  localparam int unsigned LZC_EXT_WIDTH_DEFAULT = lzc_next_pow2(49);

endpackage

// File: rtl/ipsxe_floating_point_lzc_norm_pipe_v1_0_stage.sv
// One binary-halving level of the leading-bit search (purely combinational).
//   i_x / o_x : search vector (counted polarity already mapped to zeros)
//   i_d / o_d : operand being normalised, shifted in lockstep with the search vector
//   i_c / o_c : partial count; this level owns bit CNT_W-1-LEVEL
// If the upper HALF bits of the search vector are all zero, both vectors move
// up by HALF and the level's count bit is set.
module ipsxe_floating_point_lzc_stage_v1_0 #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 6,
  parameter int unsigned LEVEL = 0
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_d,
  input  logic [CNT_W-1:0] i_c,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_d,
  output logic [CNT_W-1:0] o_c
);

  localparam int unsigned HALF = WIDTH >> (LEVEL + 1);
  localparam int unsigned CBIT = CNT_W - 1 - LEVEL;

  logic upper_zero;

  always_comb begin
    upper_zero = ~|i_x[WIDTH-1 -: HALF];
    o_x = i_x;
    o_d = i_d;
    o_c = i_c;
    if (upper_zero) begin
      o_x       = i_x << HALF;
      o_d       = i_d << HALF;
      o_c[CBIT] = 1'b1;
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_lzc_norm_pipe_v1_0.sv
// Pipelined leading-zero / leading-one counter with left normalisation.
//   i_clk, i_rst (sync, active-high), i_aclken (clock enable)
//   i_valid / o_ready  : operand handshake (o_ready is the combinational advance)
//   i_data, i_mode     : operand and counted polarity (0 = zeros, 1 = ones)
//   o_valid / i_ready  : result handshake
//   o_count, o_norm, o_all : leading count, operand << count, operand all counted bits
// The operand is zero-extended at the LSB end to a power-of-two search width and
// the halving levels are spread over PIPE_STAGES register stages; the last stage
// writes the output registers directly.
module ipsxe_floating_point_lzc_norm_pipe_v1_0
  import ipsxe_floating_point_lzc_norm_pipe_v1_0_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 49,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_aclken,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_mode,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic [DATA_WIDTH-1:0] o_norm,
  output logic                  o_all
);

  localparam int unsigned EXT_W = lzc_next_pow2(DATA_WIDTH);
  localparam int unsigned LVLS  = lzc_clog2(EXT_W);
  localparam int unsigned PAD_W = EXT_W - DATA_WIDTH;
  localparam int unsigned LAST  = PIPE_STAGES - 1;
  localparam int unsigned NREG  = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

  if (DATA_WIDTH < 2 || DATA_WIDTH > 128) begin : g_bad_width
    $error("DATA_WIDTH out of range 2..128");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("PIPE_STAGES out of range 1..4");
  end
  if (CNT_WIDTH != lzc_clog2(DATA_WIDTH + 1)) begin : g_bad_cnt
    $error("CNT_WIDTH must equal clog2(DATA_WIDTH+1)");
  end

  logic adv;

  // Per-stage combinational input and output of the halving chain.
  logic [EXT_W-1:0] sin_x  [PIPE_STAGES];
  logic [EXT_W-1:0] sin_d  [PIPE_STAGES];
  logic [LVLS-1:0]  sin_c  [PIPE_STAGES];
  logic             sin_v  [PIPE_STAGES];
  logic [EXT_W-1:0] sout_x [PIPE_STAGES];
  logic [EXT_W-1:0] sout_d [PIPE_STAGES];
  logic [LVLS-1:0]  sout_c [PIPE_STAGES];

  // Inter-stage registers (stage r feeds stage r+1).
  logic [EXT_W-1:0] x_q [NREG];
  logic [EXT_W-1:0] x_d [NREG];
  logic [EXT_W-1:0] d_q [NREG];
  logic [EXT_W-1:0] d_d [NREG];
  logic [LVLS-1:0]  c_q [NREG];
  logic [LVLS-1:0]  c_d [NREG];
  logic             v_q [NREG];
  logic             v_d [NREG];

  // Output registers.
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] norm_q,  norm_d;
  logic                  all_q,   all_d;
  logic                  all_n;

  assign adv     = i_aclken && (!valid_q || i_ready);
  assign o_ready = adv && !i_rst;

  assign o_valid = valid_q;
  assign o_count = count_q;
  assign o_norm  = norm_q;
  assign o_all   = all_q;

  // Counted polarity is folded into the search vector by inversion, so every
  // level only ever looks for zeros. Padding sits below the LSB and can only be
  // reached when the whole operand matched, which is caught as o_all.
  always_comb begin
    sin_x[0] = EXT_W'((lzc_mode_e'(i_mode) == LZC_MODE_ONES) ? ~i_data : i_data) << PAD_W;
    sin_d[0] = EXT_W'(i_data) << PAD_W;
    sin_c[0] = '0;
    sin_v[0] = i_valid;
    for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
      sin_x[s] = x_q[s-1];
      sin_d[s] = d_q[s-1];
      sin_c[s] = c_q[s-1];
      sin_v[s] = v_q[s-1];
    end
  end

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    localparam int unsigned LO = (s * LVLS) / PIPE_STAGES;
    localparam int unsigned HI = ((s + 1) * LVLS) / PIPE_STAGES;
    localparam int unsigned NL = HI - LO;

    logic [EXT_W-1:0] cx [NL+1];
    logic [EXT_W-1:0] cd [NL+1];
    logic [LVLS-1:0]  cc [NL+1];

    assign cx[0] = sin_x[s];
    assign cd[0] = sin_d[s];
    assign cc[0] = sin_c[s];

    for (genvar k = 0; k < NL; k++) begin : g_lvl
      ipsxe_floating_point_lzc_stage_v1_0 #(
        .WIDTH (EXT_W),
        .CNT_W (LVLS),
        .LEVEL (LO + k)
      ) u_lvl (
        .i_x (cx[k]),
        .i_d (cd[k]),
        .i_c (cc[k]),
        .o_x (cx[k+1]),
        .o_d (cd[k+1]),
        .o_c (cc[k+1])
      );
    end

    assign sout_x[s] = cx[NL];
    assign sout_d[s] = cd[NL];
    assign sout_c[s] = cc[NL];
  end

  always_comb begin
    x_d = x_q;
    d_d = d_q;
    c_d = c_q;
    v_d = v_q;
    for (int unsigned r = 0; r + 1 < PIPE_STAGES; r++) begin
      if (adv) begin
        x_d[r] = sout_x[r];
        d_d[r] = sout_d[r];
        c_d[r] = sout_c[r];
        v_d[r] = sin_v[r];
      end
    end
  end

  // After the full search a surviving 1 always lands in the MSB; if it did not,
  // the operand held no bit of the opposite polarity.
  always_comb begin
    all_n   = ~sout_x[LAST][EXT_W-1];
    valid_d = adv ? sin_v[LAST] : valid_q;
    count_d = count_q;
    norm_d  = norm_q;
    all_d   = all_q;
    if (adv && sin_v[LAST]) begin
      all_d   = all_n;
      count_d = all_n ? CNT_WIDTH'(DATA_WIDTH) : CNT_WIDTH'(sout_c[LAST]);
      norm_d  = all_n ? '0 : sout_d[LAST][EXT_W-1 -: DATA_WIDTH];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      count_q <= '0;
      norm_q  <= '0;
      all_q   <= 1'b0;
      v_q     <= '{default: 1'b0};
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      norm_q  <= norm_d;
      all_q   <= all_d;
      v_q     <= v_d;
    end
  end

  always_ff @(posedge i_clk) begin
    x_q <= x_d;
    d_q <= d_d;
    c_q <= c_d;
  end

endmodule
